// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS load/store requesters.
// Each channel independently grants a requester, forwards the access, relays the response, then releases.
module mem_channel_arbiter #(
   parameter int NUM_CONSUMERS = 32,
   parameter int NUM_CHANNELS  = 8,
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 16,
   parameter bit WRITE_ENABLE  = 1'b1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]             mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]             mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);
   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;

   state_t        state_q  [NUM_CHANNELS];
   state_t        state_d  [NUM_CHANNELS];
   logic [CW-1:0] owner_q  [NUM_CHANNELS];
   logic [CW-1:0] owner_d  [NUM_CHANNELS];
   logic [CW-1:0] rr_ptr_q [NUM_CHANNELS];
   logic [CW-1:0] rr_ptr_d [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] claim_q, claim_d;

   logic [NUM_CONSUMERS-1:0]            consumer_read_ready_q, consumer_read_ready_d;
   logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data_q, consumer_read_data_d;
   logic [NUM_CONSUMERS-1:0]            consumer_write_ready_q, consumer_write_ready_d;
   logic [NUM_CHANNELS-1:0]             mem_read_valid_q, mem_read_valid_d;
   logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_read_address_q, mem_read_address_d;
   logic [NUM_CHANNELS-1:0]             mem_write_valid_q, mem_write_valid_d;
   logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_write_address_q, mem_write_address_d;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_write_data_q, mem_write_data_d;

   logic [NUM_CONSUMERS-1:0] req, taken;
   logic                     found;
   int                       idx, own;

   always_comb begin
      state_d                = state_q;
      owner_d                = owner_q;
      rr_ptr_d               = rr_ptr_q;
      claim_d                = claim_q;
      consumer_read_ready_d  = consumer_read_ready_q;
      consumer_read_data_d   = consumer_read_data_q;
      consumer_write_ready_d = consumer_write_ready_q;
      mem_read_valid_d       = mem_read_valid_q;
      mem_read_address_d     = mem_read_address_q;
      mem_write_valid_d      = mem_write_valid_q;
      mem_write_address_d    = mem_write_address_q;
      mem_write_data_d       = mem_write_data_q;
      req   = consumer_read_valid | (WRITE_ENABLE ? consumer_write_valid : '0);
      // NOTE: 'taken' is blocking scratch so that each channel sees the grants
      // already made by lower-index channels in this same evaluation.
      taken = claim_q;
      found = 1'b0;
      idx   = 0;
      own   = 0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         own = int'(owner_q[c]);
         case (state_q[c])
            IDLE: begin
               found = 1'b0;
               for (int k = 0; k < NUM_CONSUMERS; k++) begin
                  idx = (int'(rr_ptr_q[c]) + k) % NUM_CONSUMERS;
                  if (!found && req[idx] && !taken[idx]) begin
                     found        = 1'b1;
                     taken[idx]   = 1'b1;
                     claim_d[idx] = 1'b1;
                     owner_d[c]   = CW'(idx);
                     rr_ptr_d[c]  = CW'((idx + 1) % NUM_CONSUMERS);
                     if (consumer_read_valid[idx]) begin
                        mem_read_valid_d[c] = 1'b1;
                        mem_read_address_d[c*ADDR_WIDTH +: ADDR_WIDTH] =
                           consumer_read_address[idx*ADDR_WIDTH +: ADDR_WIDTH];
                        state_d[c] = READ_WAIT;
                     end else begin
                        mem_write_valid_d[c] = 1'b1;
                        mem_write_address_d[c*ADDR_WIDTH +: ADDR_WIDTH] =
                           consumer_write_address[idx*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_write_data_d[c*DATA_WIDTH +: DATA_WIDTH] =
                           consumer_write_data[idx*DATA_WIDTH +: DATA_WIDTH];
                        state_d[c] = WRITE_WAIT;
                     end
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready[c]) begin
                  mem_read_valid_d[c]        = 1'b0;
                  consumer_read_ready_d[own] = 1'b1;
                  consumer_read_data_d[own*DATA_WIDTH +: DATA_WIDTH] =
                     mem_read_data[c*DATA_WIDTH +: DATA_WIDTH];
                  state_d[c] = READ_RELAY;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready[c]) begin
                  mem_write_valid_d[c]        = 1'b0;
                  consumer_write_ready_d[own] = 1'b1;
                  state_d[c]                  = WRITE_RELAY;
               end
            end
            READ_RELAY: begin
               if (!consumer_read_valid[own]) begin
                  consumer_read_ready_d[own] = 1'b0;
                  claim_d[own]               = 1'b0;
                  state_d[c]                 = IDLE;
               end
            end
            WRITE_RELAY: begin
               if (!consumer_write_valid[own]) begin
                  consumer_write_ready_d[own] = 1'b0;
                  claim_d[own]                = 1'b0;
                  state_d[c]                  = IDLE;
               end
            end
            default: state_d[c] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the per-channel arrays are few flops of control state, so they
         // take the async reset like everything else rather than being left unreset.
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c]  <= IDLE;
            owner_q[c]  <= '0;
            rr_ptr_q[c] <= '0;
         end
         claim_q                <= '0;
         consumer_read_ready_q  <= '0;
         consumer_read_data_q   <= '0;
         consumer_write_ready_q <= '0;
         mem_read_valid_q       <= '0;
         mem_read_address_q     <= '0;
         mem_write_valid_q      <= '0;
         mem_write_address_q    <= '0;
         mem_write_data_q       <= '0;
      end else begin
         state_q                <= state_d;
         owner_q                <= owner_d;
         rr_ptr_q               <= rr_ptr_d;
         claim_q                <= claim_d;
         consumer_read_ready_q  <= consumer_read_ready_d;
         consumer_read_data_q   <= consumer_read_data_d;
         consumer_write_ready_q <= consumer_write_ready_d;
         mem_read_valid_q       <= mem_read_valid_d;
         mem_read_address_q     <= mem_read_address_d;
         mem_write_valid_q      <= mem_write_valid_d;
         mem_write_address_q    <= mem_write_address_d;
         mem_write_data_q       <= mem_write_data_d;
      end
   end

   // A read-only build never reaches the write states; the write outputs are tied off.
   assign consumer_read_ready  = consumer_read_ready_q;
   assign consumer_read_data   = consumer_read_data_q;
   assign mem_read_valid       = mem_read_valid_q;
   assign mem_read_address     = mem_read_address_q;
   assign consumer_write_ready = WRITE_ENABLE ? consumer_write_ready_q : '0;
   assign mem_write_valid      = WRITE_ENABLE ? mem_write_valid_q : '0;
   assign mem_write_address    = WRITE_ENABLE ? mem_write_address_q : '0;
   assign mem_write_data       = WRITE_ENABLE ? mem_write_data_q : '0;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: a transaction-level model checked every cycle plus directed
// scenarios with hand-computed expectations; a 1-channel read-only instance covers round-robin.
module tb_mem_channel_arbiter;
   localparam int NC  = 32;
   localparam int NCH = 8;
   localparam int AW  = 8;
   localparam int DW  = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NC-1:0]     rv, wv, crr, cwr;
   logic [NC*AW-1:0]  ra, wa;
   logic [NC*DW-1:0]  wd, crd;
   logic [NCH-1:0]    mrv, mrr, mwv, mwr;
   logic [NCH*AW-1:0] mra, mwa;
   logic [NCH*DW-1:0] mrd, mwd;
   logic [NCH-1:0]    rd_auto, rd_force, wr_auto, wr_force;

   assign mrr = (mrv & rd_auto) | rd_force;
   assign mwr = (mwv & wr_auto) | wr_force;

   mem_channel_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW),
                         .DATA_WIDTH(DW), .WRITE_ENABLE(1'b1)) dut (
      .clk(clk), .reset(rst_n),
      .consumer_read_valid(rv), .consumer_read_address(ra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(wv), .consumer_write_address(wa),
      .consumer_write_data(wd), .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra),
      .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa),
      .mem_write_data(mwd), .mem_write_ready(mwr));

   // Single-channel, read-only instance
   logic [NC-1:0]    r_rv, r_wv, r_crr, r_cwr;
   logic [NC*AW-1:0] r_ra, r_wa;
   logic [NC*DW-1:0] r_wd, r_crd;
   logic [0:0]       r_mrv, r_mrr, r_mwv, r_mwr;
   logic [AW-1:0]    r_mra, r_mwa;
   logic [DW-1:0]    r_mrd, r_mwd;
   assign r_mrr = r_mrv;
   assign r_mwr = r_mwv;
   assign r_mrd = 16'hC0DE;

   mem_channel_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_WIDTH(AW),
                         .DATA_WIDTH(DW), .WRITE_ENABLE(1'b0)) dut_rr (
      .clk(clk), .reset(rst_n),
      .consumer_read_valid(r_rv), .consumer_read_address(r_ra),
      .consumer_read_ready(r_crr), .consumer_read_data(r_crd),
      .consumer_write_valid(r_wv), .consumer_write_address(r_wa),
      .consumer_write_data(r_wd), .consumer_write_ready(r_cwr),
      .mem_read_valid(r_mrv), .mem_read_address(r_mra),
      .mem_read_ready(r_mrr), .mem_read_data(r_mrd),
      .mem_write_valid(r_mwv), .mem_write_address(r_mwa),
      .mem_write_data(r_mwd), .mem_write_ready(r_mwr));

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: each channel holds at most one transfer (kind 1 read, 2 write)
   // for consumer 'who'; 'done' means memory has answered and the response is being relayed.
   int            m_kind  [NCH];
   int            m_who   [NCH];
   bit            m_done  [NCH];
   int            m_rr    [NCH];
   logic [AW-1:0] m_addr  [NCH];
   logic [DW-1:0] m_wdata [NCH];
   logic [DW-1:0] m_rdata [NC];

   logic [NC-1:0]     s_rv, s_wv;
   logic [NC*AW-1:0]  s_ra, s_wa;
   logic [NC*DW-1:0]  s_wd;
   logic [NCH-1:0]    s_mrr, s_mwr;
   logic [NCH*DW-1:0] s_mrd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_kind[c] = 0; m_who[c] = 0; m_done[c] = 1'b0; m_rr[c] = 0;
            m_addr[c] = '0; m_wdata[c] = '0;
         end
         for (int j = 0; j < NC; j++) m_rdata[j] = '0;
      end else begin
         bit busy [NC];
         bit got;
         int j;
         for (int i = 0; i < NC; i++) busy[i] = 1'b0;
         for (int c = 0; c < NCH; c++) if (m_kind[c] != 0) busy[m_who[c]] = 1'b1;
         for (int c = 0; c < NCH; c++) begin
            if (m_kind[c] == 0) begin
               got = 1'b0;
               for (int k = 0; k < NC; k++) begin
                  j = (m_rr[c] + k) % NC;
                  if (!got && (s_rv[j] || s_wv[j]) && !busy[j]) begin
                     got = 1'b1; busy[j] = 1'b1;
                     m_who[c] = j; m_done[c] = 1'b0; m_rr[c] = (j + 1) % NC;
                     m_kind[c]  = s_rv[j] ? 1 : 2;
                     m_addr[c]  = s_rv[j] ? s_ra[j*AW +: AW] : s_wa[j*AW +: AW];
                     m_wdata[c] = s_wd[j*DW +: DW];
                  end
               end
            end else if (!m_done[c]) begin
               if (m_kind[c] == 1 && s_mrr[c]) begin
                  m_done[c] = 1'b1;
                  m_rdata[m_who[c]] = s_mrd[c*DW +: DW];
               end
               if (m_kind[c] == 2 && s_mwr[c]) m_done[c] = 1'b1;
            end else begin
               if ((m_kind[c] == 1 && !s_rv[m_who[c]]) || (m_kind[c] == 2 && !s_wv[m_who[c]])) begin
                  m_kind[c] = 0; m_done[c] = 1'b0;
               end
            end
         end
      end
   end

   // Compare on the falling edge, then snapshot the inputs the next rising edge will act on.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [NCH-1:0] e_mrv, e_mwv;
         logic [NC-1:0]  e_crr, e_cwr;
         e_mrv = '0; e_mwv = '0; e_crr = '0; e_cwr = '0;
         for (int c = 0; c < NCH; c++) begin
            if (m_kind[c] == 1 && !m_done[c]) e_mrv[c] = 1'b1;
            if (m_kind[c] == 2 && !m_done[c]) e_mwv[c] = 1'b1;
            if (m_kind[c] == 1 && m_done[c])  e_crr[m_who[c]] = 1'b1;
            if (m_kind[c] == 2 && m_done[c])  e_cwr[m_who[c]] = 1'b1;
         end
         check("model_mem_read_valid", 64'(mrv), 64'(e_mrv));
         check("model_mem_write_valid", 64'(mwv), 64'(e_mwv));
         check("model_consumer_read_ready", 64'(crr), 64'(e_crr));
         check("model_consumer_write_ready", 64'(cwr), 64'(e_cwr));
         for (int c = 0; c < NCH; c++) begin
            if (e_mrv[c]) check("model_mem_read_address", 64'(mra[c*AW +: AW]), 64'(m_addr[c]));
            if (e_mwv[c]) begin
               check("model_mem_write_address", 64'(mwa[c*AW +: AW]), 64'(m_addr[c]));
               check("model_mem_write_data", 64'(mwd[c*DW +: DW]), 64'(m_wdata[c]));
            end
         end
         for (int j = 0; j < NC; j++)
            if (e_crr[j]) check("model_consumer_read_data", 64'(crd[j*DW +: DW]), 64'(m_rdata[j]));
      end
      s_rv = rv; s_wv = wv; s_ra = ra; s_wa = wa; s_wd = wd;
      s_mrr = mrr; s_mwr = mwr; s_mrd = mrd;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
      rd_auto = '0; rd_force = '0; wr_auto = '0; wr_force = '0;
      for (int c = 0; c < NCH; c++) mrd[c*DW +: DW] = 16'hA000 + DW'(c);
      r_rv = '0; r_wv = '0; r_ra = '0; r_wa = '0; r_wd = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic consumer_step();
      for (int i = 0; i < NC; i++) begin
         if (crr[i]) rv[i] = 1'b0;
         if (cwr[i]) wv[i] = 1'b0;
      end
   endtask

   int served [NC];
   int seq [4];
   int cyc, n, prev;
   bit bad_wr;
   logic [NC-1:0] once;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      cmp_en = 1'b1;
      check("reset_mem_valids", 64'({mrv, mwv}), 64'h0);
      check("reset_consumer_readies", 64'({crr, cwr}), 64'h0);

      // Single read; a ready on idle channel 1 must be ignored
      rv[3] = 1'b1; ra[3*AW +: AW] = 8'h2A; rd_force = 8'h02;
      tick();
      check("rd1_mem_valid_c1", 64'(mrv), 64'h01);
      check("rd1_mem_addr_c1", 64'(mra[AW-1:0]), 64'h2A);
      tick();
      check("rd1_idle_ready_ignored", 64'(crr), 64'h0);
      check("rd1_mem_valid_held_c2", 64'(mrv), 64'h01);
      rd_force = 8'h01; mrd[DW-1:0] = 16'h1234;
      tick();
      rd_force = '0;
      check("rd1_cons_ready_c3", 64'(crr), 64'h8);
      check("rd1_cons_data_c3", 64'(crd[3*DW +: DW]), 64'h1234);
      check("rd1_mem_valid_drop", 64'(mrv), 64'h0);
      rv[3] = 1'b0;
      tick();
      check("rd1_released", 64'(crr), 64'h0);

      // Contention: 32 readers, 8 channels, zero-wait memory
      do_reset();
      for (int i = 0; i < NC; i++) ra[i*AW +: AW] = AW'(i);
      rv = '1; rd_auto = '1;
      for (int i = 0; i < NC; i++) served[i] = 0;
      tick();
      check("cont_first_grants", 64'(mrv), 64'hFF);
      for (int c = 0; c < NCH; c++) check("cont_grant_addr", 64'(mra[c*AW +: AW]), 64'(c));
      cyc = 0;
      while (rv != '0 && cyc < 200) begin
         tick();
         cyc++;
         for (int i = 0; i < NC; i++)
            if (crr[i]) begin served[i]++; rv[i] = 1'b0; end
      end
      for (int i = 0; i < NC; i++) once[i] = (served[i] == 1);
      check("cont_all_served", 64'(rv), 64'h0);
      check("cont_served_once", 64'(once), 64'hFFFF_FFFF);
      tick();
      check("cont_quiet", 64'({mrv, crr}), 64'h0);

      // Write with a 4-cycle memory stall; late changes on the consumer side are ignored
      do_reset();
      wv[5] = 1'b1; wa[5*AW +: AW] = 8'h10; wd[5*DW +: DW] = 16'hBEEF;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("wr_valid_held", 64'(mwv), 64'h01);
         check("wr_addr_stable", 64'(mwa[AW-1:0]), 64'h10);
         check("wr_data_stable", 64'(mwd[DW-1:0]), 64'hBEEF);
         check("wr_no_early_ack", 64'(cwr), 64'h0);
         if (k == 1) begin wa[5*AW +: AW] = 8'hFF; wd[5*DW +: DW] = 16'h0000; end
      end
      tick();
      wr_force = 8'h01;
      check("wr_valid_c5", 64'(mwv), 64'h01);
      tick();
      wr_force = '0;
      check("wr_ack_c6", 64'(cwr), 64'h20);
      check("wr_mem_valid_drop", 64'(mwv), 64'h0);
      wv[5] = 1'b0;
      tick();
      check("wr_ack_released", 64'(cwr), 64'h0);

      // Read and write from the same consumer: read first, write after release
      do_reset();
      rv[7] = 1'b1; wv[7] = 1'b1;
      ra[7*AW +: AW] = 8'h33; wa[7*AW +: AW] = 8'h44; wd[7*DW +: DW] = 16'h5555;
      rd_auto = '1; wr_auto = '1;
      tick();
      check("rw_read_first", 64'(mrv), 64'h01);
      check("rw_no_write_yet", 64'(mwv), 64'h0);
      check("rw_read_addr", 64'(mra[AW-1:0]), 64'h33);
      consumer_step();
      tick();
      check("rw_read_ready", 64'(crr), 64'h80);
      check("rw_read_data", 64'(crd[7*DW +: DW]), 64'hA000);
      consumer_step();
      tick();
      check("rw_idle_gap", 64'(mwv), 64'h0);
      consumer_step();
      tick();
      check("rw_write_grant", 64'(mwv), 64'h01);
      check("rw_write_addr", 64'(mwa[AW-1:0]), 64'h44);
      check("rw_write_data", 64'(mwd[DW-1:0]), 64'h5555);
      consumer_step();
      tick();
      check("rw_write_ack", 64'(cwr), 64'h80);
      consumer_step();
      tick();

      // Asynchronous reset in READ_WAIT, then the held request is re-granted on channel 0
      do_reset();
      rv[2] = 1'b1; ra[2*AW +: AW] = 8'h77;
      tick();
      check("ar_in_wait", 64'(mrv), 64'h01);
      #1 rst_n = 1'b0;
      #1;
      check("ar_mem_valids_zero", 64'({mrv, mwv}), 64'h0);
      check("ar_mem_addr_zero", 64'(mra) | 64'(mwa), 64'h0);
      check("ar_mem_wdata_zero", 64'(mwd), 64'h0);
      check("ar_readies_zero", 64'({crr, cwr}), 64'h0);
      check("ar_data_zero", 64'(crd[2*DW +: DW]), 64'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("ar_regrant_ch0", 64'(mrv), 64'h01);
      check("ar_regrant_addr", 64'(mra[AW-1:0]), 64'h77);

      // Round-robin on the single-channel read-only instance; write requests ignored
      do_reset();
      for (int i = 0; i < NC; i++) r_ra[i*AW +: AW] = AW'(i);
      r_rv[1:0] = 2'b11;
      r_wv[5] = 1'b1; r_wa[5*AW +: AW] = 8'h55; r_wd[5*DW +: DW] = 16'h1111;
      n = 0; prev = 0; bad_wr = 1'b0; cyc = 0;
      while (n < 4 && cyc < 100) begin
         tick();
         cyc++;
         if (r_mrv[0] && prev == 0) begin seq[n] = int'(r_mra); n++; end
         prev = int'(r_mrv[0]);
         if (r_mwv[0] || r_cwr != '0) bad_wr = 1'b1;
         for (int i = 0; i < 2; i++) r_rv[i] = !r_crr[i];
      end
      check("rr_grant_count", 64'(n), 64'd4);
      check("rr_grant0", 64'(seq[0]), 64'd0);
      check("rr_grant1", 64'(seq[1]), 64'd1);
      check("rr_grant2", 64'(seq[2]), 64'd0);
      check("rr_grant3", 64'(seq[3]), 64'd1);
      check("we0_write_ignored", 64'(bad_wr), 64'd0);

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
